intra_mode_decision: RTL and testbench

- Mode-decision stage directly downstream of the 4x4 intra prediction-sample generator.
- Consumes one 16-sample predicted block per valid beat, in mode order 0 (planar), 1 (DC), 2..34 (angular).
- Computes the SAD of each predicted block against the original 4x4 block and tracks the minimum.
- After all NUM_MODES predictions, reports the best mode and its cost to the entropy/reconstruction control.

---
 rtl/intra_mode_decision.sv | 124 ++++++++++++
 tb/tb_intra_mode_decision.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/intra_mode_decision.sv
// rtl/intra_mode_decision.sv - 4x4 intra mode decision: per-mode SAD, running minimum, best-mode report
module intra_mode_decision #(
    parameter int NUM_MODES = 35,
    parameter int PIX_W     = 8,
    parameter int COST_W    = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [0:16*PIX_W-1]   org_blk,
    input  logic [0:16*PIX_W-1]   pre_sam,
    input  logic                  i_valid,
    output logic [5:0]            best_mode,
    output logic [COST_W-1:0]     best_cost,
    output logic                  o_done,
    output logic                  busy
);

    typedef enum logic [1:0] {IDLE, ACCUM, FLUSH, REPORT} state_t;

    state_t                state;
    state_t                state_nxt;
    logic [0:16*PIX_W-1]   org_q;
    logic [5:0]            beat_cnt;
    logic                  accept;
    logic                  last_beat;
    logic [PIX_W-1:0]      ad_nxt [16];
    logic                  s1_valid;
    logic [5:0]            s1_mode;
    logic [PIX_W-1:0]      s1_ad [16];
    logic [COST_W-1:0]     tree_sum;
    logic                  s2_valid;
    logic [5:0]            s2_mode;
    logic [COST_W-1:0]     s2_cost;
    logic [COST_W-1:0]     running_min;
    logic [5:0]            running_mode;
    logic [5:0]            best_mode_q;
    logic [COST_W-1:0]     best_cost_q;

    // A beat sharing the cycle with start belongs to neither block
    assign accept    = (state == ACCUM) && i_valid && !start;
    assign last_beat = accept && (beat_cnt == 6'(NUM_MODES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = ACCUM;
            ACCUM:   if (start) state_nxt = ACCUM;
                     else if (last_beat) state_nxt = FLUSH;
            FLUSH:   if (start) state_nxt = ACCUM;
                     else if (!s1_valid) state_nxt = REPORT;
            REPORT:  state_nxt = start ? ACCUM : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // In the report cycle the final stage-3 result is forwarded so it is valid with o_done
    always_comb begin
        busy      = (state != IDLE);
        o_done    = (state == REPORT);
        best_mode = o_done ? running_mode : best_mode_q;
        best_cost = o_done ? running_min  : best_cost_q;
    end

    always_comb begin
        for (int i = 0; i < 16; i++) begin
            logic [PIX_W-1:0] o;
            logic [PIX_W-1:0] p;
            o = org_q[i*PIX_W +: PIX_W];
            p = pre_sam[i*PIX_W +: PIX_W];
            ad_nxt[i] = (o > p) ? (o - p) : (p - o);
        end
    end

    always_comb begin
        tree_sum = '0;
        for (int i = 0; i < 16; i++) tree_sum = tree_sum + COST_W'(s1_ad[i]);
    end

    always_ff @(posedge clk) begin
        if (start) org_q <= org_blk;
        s1_ad   <= ad_nxt;
        s1_mode <= beat_cnt;
        s2_cost <= tree_sum;
        s2_mode <= s1_mode;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            beat_cnt     <= '0;
            s1_valid     <= 1'b0;
            s2_valid     <= 1'b0;
            running_min  <= '1;
            running_mode <= '0;
            best_mode_q  <= '0;
            best_cost_q  <= '0;
        end else begin
            s1_valid <= accept;
            s2_valid <= s1_valid;
            if (state == REPORT) begin
                best_mode_q <= running_mode;
                best_cost_q <= running_min;
            end
            if (start) begin
                beat_cnt     <= '0;
                s2_valid     <= 1'b0;
                running_min  <= '1;
                running_mode <= '0;
            end else begin
                if (accept) beat_cnt <= beat_cnt + 6'd1;
                if (s2_valid && (s2_cost < running_min)) begin
                    running_min  <= s2_cost;
                    running_mode <= s2_mode;
                end
            end
        end
    end

endmodule

// File: tb/tb_intra_mode_decision.sv
// tb/tb_intra_mode_decision.sv - randomized self-checking bench for intra_mode_decision
module tb_intra_mode_decision;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [0:127] org_blk;
    logic [0:127] pre_sam;
    logic         i_valid;
    logic [5:0]   best_mode;
    logic [11:0]  best_cost;
    logic         o_done;
    logic         busy;

    intra_mode_decision dut (
        .clk(clk), .rst(rst), .start(start), .org_blk(org_blk), .pre_sam(pre_sam),
        .i_valid(i_valid), .best_mode(best_mode), .best_cost(best_cost),
        .o_done(o_done), .busy(busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int          total = 0;
    int          bad = 0;
    int          done_cnt = 0;
    int          done_cyc = -1;
    logic [5:0]  cap_mode;
    logic [11:0] cap_cost;
    int          last_cyc;

    always @(negedge clk) begin
        if (o_done === 1'b1) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
            cap_mode <= best_mode;
            cap_cost <= best_cost;
        end
    end

    logic [0:127] org_v;
    logic [0:127] pre_q [35];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic [0:127] fill(input int val);
        logic [0:127] v;
        for (int i = 0; i < 16; i++) v[i*8 +: 8] = 8'(val);
        return v;
    endfunction

    function automatic int sad(input logic [0:127] o, input logic [0:127] p);
        int s = 0;
        for (int i = 0; i < 16; i++) begin
            int a = int'(o[i*8 +: 8]);
            int b = int'(p[i*8 +: 8]);
            s += (a > b) ? a - b : b - a;
        end
        return s;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // The start-cycle beat carries a zero-cost block that must not be counted
    task automatic begin_block(input string name);
        start = 1'b1; org_blk = org_v; i_valid = 1'b1; pre_sam = org_v;
        step();
        start = 1'b0; i_valid = 1'b0;
        check({name, "_busy_after_start"}, busy, 1);
    endtask

    task automatic feed(input int n, input int gap);
        for (int m = 0; m < n; m++) begin
            if (gap == 1 && m > 0) begin i_valid = 1'b0; step(); end
            if (gap == 2) begin
                int g = $urandom_range(0, 2);
                i_valid = 1'b0;
                repeat (g) step();
            end
            i_valid = 1'b1; pre_sam = pre_q[m]; last_cyc = cyc;
            step();
        end
        i_valid = 1'b0;
    endtask

    task automatic run_block(input string name, input int gap, input int extras);
        int d0 = done_cnt;
        int em = 0;
        int ec = sad(org_v, pre_q[0]);
        for (int m = 1; m < 35; m++) begin
            int c = sad(org_v, pre_q[m]);
            if (c < ec) begin ec = c; em = m; end
        end
        begin_block(name);
        feed(35, gap);
        for (int e = 0; e < extras; e++) begin
            i_valid = 1'b1; pre_sam = org_v;
            step();
        end
        i_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (done_cnt != d0) break;
            step();
        end
        repeat (3) step();
        check({name, "_done_pulses"}, done_cnt - d0, 1);
        check({name, "_done_latency"}, done_cyc - last_cyc, 3);
        check({name, "_mode"}, cap_mode, em);
        check({name, "_cost"}, cap_cost, ec);
        check({name, "_mode_held"}, best_mode, em);
        check({name, "_cost_held"}, best_cost, ec);
        check({name, "_busy_idle"}, busy, 0);
    endtask

    initial begin
        rst = 1'b0; start = 1'b0; i_valid = 1'b0; org_blk = '0; pre_sam = '0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", o_done, 0);
        check("rst_mode", best_mode, 0);
        check("rst_cost", best_cost, 0);
        @(negedge clk); rst = 1'b1;
        step();

        // Beats in IDLE are ignored
        i_valid = 1'b1; pre_sam = fill(8'h11);
        repeat (3) step();
        i_valid = 1'b0;
        check("idle_busy", busy, 0);
        check("idle_done_cnt", done_cnt, 0);

        org_v = fill(8'h40);
        for (int m = 0; m < 35; m++) pre_q[m] = fill(8'h41);
        pre_q[7] = org_v;
        run_block("s1", 0, 0);

        org_v = fill(8'h80);
        for (int m = 0; m < 35; m++)
            for (int i = 0; i < 16; i++)
                pre_q[m][i*8 +: 8] = ($urandom_range(0, 1) != 0) ? 8'h82 : 8'h7E;
        run_block("s2", 0, 0);

        org_v = fill(8'hFF);
        for (int m = 0; m < 35; m++) pre_q[m] = fill(8'h00);
        pre_q[34] = fill(8'hFE);
        run_block("s3", 0, 0);

        // Asynchronous reset between clock edges, mid-ACCUM
        org_v = fill(8'h40);
        for (int m = 0; m < 35; m++) pre_q[m] = fill(8'h41);
        pre_q[7] = org_v;
        begin_block("s6a");
        feed(5, 0);
        #3 rst = 1'b0;
        #1;
        check("s6_rst_mode", best_mode, 0);
        check("s6_rst_cost", best_cost, 0);
        check("s6_rst_busy", busy, 0);
        check("s6_rst_done", o_done, 0);
        #2 rst = 1'b1;
        step();
        run_block("s6", 0, 0);

        run_block("s4", 1, 2);

        // Aborted block: mode 3 exact, only 10 beats
        org_v = fill(8'h30);
        for (int m = 0; m < 35; m++) pre_q[m] = fill(8'h33);
        pre_q[3] = org_v;
        begin_block("s5a");
        feed(10, 0);
        org_v = fill(8'h90);
        for (int m = 0; m < 35; m++) pre_q[m] = fill(8'h95);
        pre_q[20] = org_v;
        run_block("s5", 0, 0);

        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 16; i++) org_v[i*8 +: 8] = 8'($urandom_range(0, 255));
            for (int m = 0; m < 35; m++) begin
                if (m > 0 && $urandom_range(0, 3) == 0) pre_q[m] = pre_q[$urandom_range(0, m - 1)];
                else for (int i = 0; i < 16; i++) pre_q[m][i*8 +: 8] = 8'($urandom_range(0, 255));
            end
            run_block($sformatf("rnd%0d", r), 2, $urandom_range(0, 2));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
